start_screen_placer: RTL and testbench



---
 rtl/start_screen_placer.sv | 113 +++++++++++
 tb/tb_start_screen_placer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/start_screen_placer.sv
// Start-screen title placer: maps the VGA scan pixel to bitmap offsets and slides the title into place.
// Optional blinking at rest is enabled by defining START_BLINK_EN.
module start_screen_placer #(
    parameter int unsigned OBJECT_WIDTH_X  = 64,
    parameter int unsigned OBJECT_HEIGHT_Y = 64,
    parameter int unsigned REST_X          = 288,
    parameter int unsigned START_Y         = 0,
    parameter int unsigned REST_Y          = 208,
    parameter int unsigned SLIDE_STEP      = 2,
    parameter int unsigned BLINK_PERIOD    = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        showReq,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        atRest
);

    typedef enum logic [1:0] {IDLE, SLIDE, REST} state_t;

    state_t      state;
    logic [10:0] topLeftY;
    logic        visible;
    logic [11:0] next_y;
    logic [11:0] left_x, right_x, top_y, bottom_y, px, py;
    logic        inside_c;

    always_comb begin
        px       = {1'b0, pixelX};
        py       = {1'b0, pixelY};
        left_x   = 12'(REST_X);
        right_x  = 12'(REST_X + OBJECT_WIDTH_X);
        top_y    = {1'b0, topLeftY};
        bottom_y = {1'b0, topLeftY} + 12'(OBJECT_HEIGHT_Y);
        next_y   = {1'b0, topLeftY} + 12'(SLIDE_STEP);
        // Gating on showReq blanks the object on the very edge an abort is taken.
        inside_c = showReq && (state != IDLE) && visible
                   && (px >= left_x) && (px < right_x)
                   && (py >= top_y) && (py < bottom_y);
    end

`ifdef START_BLINK_EN
    localparam int unsigned BC_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    logic [BC_W-1:0] blinkCnt;
`else
    assign visible = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            topLeftY        <= 11'(START_Y);
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
            atRest          <= 1'b0;
`ifdef START_BLINK_EN
            blinkCnt        <= '0;
            visible         <= 1'b1;
`endif
        end else begin
            InsideRectangle <= inside_c;
            offsetX         <= inside_c ? (pixelX - 11'(REST_X)) : '0;
            offsetY         <= inside_c ? (pixelY - topLeftY) : '0;

            if (!showReq) begin
                state    <= IDLE;
                topLeftY <= 11'(START_Y);
                atRest   <= 1'b0;
`ifdef START_BLINK_EN
                visible  <= 1'b1;
`endif
            end else if (startOfFrame) begin
                case (state)
                    IDLE: begin
                        state    <= SLIDE;
                        topLeftY <= 11'(START_Y);
                    end
                    SLIDE: begin
                        if (next_y >= 12'(REST_Y)) begin
                            state    <= REST;
                            topLeftY <= 11'(REST_Y);
                            atRest   <= 1'b1;
`ifdef START_BLINK_EN
                            blinkCnt <= '0;
                            visible  <= 1'b1;
`endif
                        end else begin
                            topLeftY <= next_y[10:0];
                        end
                    end
                    REST: begin
`ifdef START_BLINK_EN
                        if (blinkCnt == BC_W'(BLINK_PERIOD - 1)) begin
                            blinkCnt <= '0;
                            visible  <= ~visible;
                        end else begin
                            blinkCnt <= blinkCnt + 1'b1;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_start_screen_placer.sv
// Bench for start_screen_placer: frame-level model checked every cycle plus directed literal checks.
module tb_start_screen_placer;

    localparam int W = 64, H = 64, RX = 288, SY = 0, RY = 208, STEP = 2, BP = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        showReq = 1'b1;
    logic [10:0] pixelX = 11'd300;
    logic [10:0] pixelY = 11'd10;
    logic        InsideRectangle;
    logic [10:0] offsetX, offsetY;
    logic        atRest;

    int checks = 0;
    int errors = 0;

    start_screen_placer #(
        .OBJECT_WIDTH_X(W), .OBJECT_HEIGHT_Y(H), .REST_X(RX), .START_Y(SY),
        .REST_Y(RY), .SLIDE_STEP(STEP), .BLINK_PERIOD(BP)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .showReq(showReq),
        .pixelX(pixelX), .pixelY(pixelY), .InsideRectangle(InsideRectangle),
        .offsetX(offsetX), .offsetY(offsetY), .atRest(atRest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: object is "on" once a frame has started with showReq held,
    // sits at START_Y + STEP*(frames since start) capped at REST_Y, and blinks by frame count at rest.
    bit m_on, m_rest;
    int m_y, m_rf;
    int e_in, e_ox, e_oy, e_rest;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_on = 0; m_rest = 0; m_y = SY; m_rf = 0;
            e_in = 0; e_ox = 0; e_oy = 0; e_rest = 0;
        end else begin
            int  x, y;
            bit  vis;
            x = int'(pixelX);
            y = int'(pixelY);
`ifdef START_BLINK_EN
            vis = !m_rest || ((m_rf / BP) % 2 == 0);
`else
            vis = 1;
`endif
            e_in = (showReq && m_on && vis && x >= RX && x < RX + W && y >= m_y && y < m_y + H) ? 1 : 0;
            e_ox = e_in ? x - RX : 0;
            e_oy = e_in ? y - m_y : 0;
            if (!showReq) begin
                m_on = 0; m_rest = 0; m_y = SY; m_rf = 0;
            end else if (startOfFrame) begin
                if (!m_on) begin
                    m_on = 1; m_y = SY;
                end else if (!m_rest) begin
                    m_y = (m_y + STEP >= RY) ? RY : m_y + STEP;
                    if (m_y == RY) begin m_rest = 1; m_rf = 0; end
                end else begin
                    m_rf++;
                end
            end
            e_rest = m_rest;
        end
    end

    always @(negedge clk) begin
        chk("model_inside", int'(InsideRectangle), e_in);
        chk("model_offsetX", int'(offsetX), e_ox);
        chk("model_offsetY", int'(offsetY), e_oy);
        chk("model_atRest", int'(atRest), e_rest);
    end

    task automatic frame();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic look(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
        @(negedge clk);
    endtask

    task automatic expect_px(input string name, input int ins, input int ox, input int oy);
        chk({name, "_in"}, int'(InsideRectangle), ins);
        chk({name, "_ox"}, int'(offsetX), ox);
        chk({name, "_oy"}, int'(offsetY), oy);
    endtask

    initial begin
        // reset state with showReq already high
        @(negedge clk);
        expect_px("reset", 0, 0, 0);
        chk("reset_atRest", int'(atRest), 0);
        @(negedge clk);
        reset = 1'b0;
        look(300, 10);
        look(300, 10);
        expect_px("pre_frame", 0, 0, 0);

        // entry frame places object at START_Y
        frame();
        look(300, 10);
        expect_px("slide0", 1, 12, 10);

        frames(103);
        chk("atRest_before_last", int'(atRest), 0);
        frame();
        chk("atRest_after_104", int'(atRest), 1);
        look(288, 208);
        expect_px("rest_corner", 1, 0, 0);
        look(351, 271);
        expect_px("rest_far_corner", 1, 63, 63);
        look(352, 271);
        expect_px("rest_right_excl", 0, 0, 0);
        look(351, 272);
        expect_px("rest_bottom_excl", 0, 0, 0);
        look(287, 208);
        expect_px("rest_left_out", 0, 0, 0);
        look(288, 207);
        expect_px("rest_top_out", 0, 0, 0);

        // blinking at rest
        look(300, 220);
        frames(29);
        expect_px("blink_29", 1, 12, 12);
        frame();
`ifdef START_BLINK_EN
        expect_px("blink_30", 0, 0, 0);
`else
        expect_px("blink_30", 1, 12, 12);
`endif
        frames(30);
        expect_px("blink_60", 1, 12, 12);

        // abort from REST without a frame pulse
        showReq = 1'b0;
        @(negedge clk);
        showReq = 1'b1;
        chk("abort_rest_atRest", int'(atRest), 0);
        expect_px("abort_rest", 0, 0, 0);

        // slide to Y=100, then abort on the same cycle as a frame pulse
        frame();
        frames(50);
        look(300, 100);
        expect_px("slide100", 1, 12, 0);
        startOfFrame = 1'b1;
        showReq = 1'b0;
        @(negedge clk);
        startOfFrame = 1'b0;
        showReq = 1'b1;
        expect_px("abort_edge", 0, 0, 0);
        chk("abort_atRest", int'(atRest), 0);
        look(300, 100);
        expect_px("abort_idle", 0, 0, 0);
        frame();
        look(300, 63);
        expect_px("reslide_y63", 1, 12, 63);
        look(300, 64);
        expect_px("reslide_y64", 0, 0, 0);

        // async reset in the middle of REST
        frames(104);
        look(300, 220);
        expect_px("rest_again", 1, 12, 12);
        #2 reset = 1'b1;
        #1;
        expect_px("async_reset", 0, 0, 0);
        chk("async_reset_atRest", int'(atRest), 0);
        @(negedge clk);
        reset = 1'b0;
        look(300, 10);
        expect_px("post_reset_idle", 0, 0, 0);
        frame();
        look(300, 10);
        expect_px("post_reset_slide", 1, 12, 10);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
